// File: rtl/dlx_fetch_queue.sv
// Fetch stage: drives the fetch PC to the ROM and queues {word, pc} for the pipeline, 1-cycle fetch-to-valid.
// Fetch stalls (rom_addr holds) only while the queue is full and the head is not taken; a redirect flushes everything.
module dlx_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [31:0]                rom_addr,
    input  logic [31:0]                rom_data,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst_out,
    output logic [31:0]                inst_pc,
    input  logic                       redirect_en,
    input  logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          pop, push;

    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & inst_ready;
    assign push       = (count_q < FULL_CNT) | pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_en) begin
            // Flush: the head shown this cycle is squashed downstream, so nothing is popped.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc & ~32'h3;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + AW'(1);
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Storage is never cleared; the empty mask on the outputs hides stale entries.
    always_ff @(posedge clock) begin
        if (!reset && !redirect_en && push) begin
            inst_mem_q[wr_ptr_q] <= rom_data;
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    assign rom_addr = fetch_pc_q;
    assign count    = count_q;
    assign inst_out = inst_valid ? inst_mem_q[rd_ptr_q] : 32'h0;
    assign inst_pc  = inst_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;

endmodule

// File: tb/tb_dlx_fetch_queue.sv
// Directed bench for dlx_fetch_queue: vector table plus a throughput sequence.
module tb_dlx_fetch_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [2:0]  count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dlx_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clock      (clock),
        .reset      (reset),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .count      (count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign rom_data = rom_f(rom_addr);

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rde;
        logic [31:0] rpc;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rdy, input logic rde, input logic [31:0] rpc,
                       input logic e_vld, input logic [31:0] e_pc, input logic [2:0] e_cnt,
                       input logic [31:0] e_addr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rde = rde; v.rpc = rpc;
        v.e_vld = e_vld; v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_addr = e_addr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s row %0d: got %08h expected %08h", name, idx, act, exp);
    endtask

    task automatic chk_outputs(input int idx, input logic e_vld, input logic [31:0] e_pc,
                               input logic [2:0] e_cnt, input logic [31:0] e_addr);
        chk("inst_valid", idx, {31'b0, inst_valid}, {31'b0, e_vld});
        chk("inst_pc",    idx, inst_pc, e_pc);
        chk("count",      idx, {29'b0, count}, {29'b0, e_cnt});
        chk("rom_addr",   idx, rom_addr, e_addr);
        chk("inst_out",   idx, inst_out, e_vld ? rom_f(e_pc) : 32'h0);
    endtask

    initial begin
        // rst rdy rde rpc | vld pc cnt addr  (expected = state before this row's edge)
        // Stream after reset
        add(0,1,0,0,            0,32'h0,0,32'h0);
        add(0,1,0,0,            1,32'h0,1,32'h4);
        add(0,1,0,0,            1,32'h4,1,32'h8);
        add(0,1,0,0,            1,32'h8,1,32'hC);
        add(1,0,0,0,            1,32'hC,1,32'h10);
        // Stall 10 cycles after reset, then release
        add(0,0,0,0,            0,32'h0,0,32'h0);
        add(0,0,0,0,            1,32'h0,1,32'h4);
        add(0,0,0,0,            1,32'h0,2,32'h8);
        add(0,0,0,0,            1,32'h0,3,32'hC);
        for (int i = 0; i < 6; i++) add(0,0,0,0, 1,32'h0,4,32'h10);
        add(0,1,0,0,            1,32'h0,4,32'h10);
        add(0,1,0,0,            1,32'h4,4,32'h14);
        add(0,1,0,0,            1,32'h8,4,32'h18);
        add(0,1,0,0,            1,32'hC,4,32'h1C);
        add(0,1,0,0,            1,32'h10,4,32'h20);
        add(0,0,0,0,            1,32'h14,4,32'h24);
        add(1,0,0,0,            1,32'h14,4,32'h24);
        // Redirect to 0x40 at count=3
        add(0,0,0,0,            0,32'h0,0,32'h0);
        add(0,0,0,0,            1,32'h0,1,32'h4);
        add(0,0,0,0,            1,32'h0,2,32'h8);
        add(0,1,1,32'h40,       1,32'h0,3,32'hC);
        add(0,1,0,0,            0,32'h0,0,32'h40);
        add(0,0,0,0,            1,32'h40,1,32'h44);
        // Fill, then redirect to 0x80 while full with pop
        add(0,0,0,0,            1,32'h40,2,32'h48);
        add(0,0,0,0,            1,32'h40,3,32'h4C);
        add(0,1,1,32'h80,       1,32'h40,4,32'h50);
        add(0,1,0,0,            0,32'h0,0,32'h80);
        // Misaligned target, then wrap at top of address space
        add(0,1,1,32'h43,       1,32'h80,1,32'h84);
        add(0,1,0,0,            0,32'h0,0,32'h40);
        add(0,1,1,32'hFFFFFFFC, 1,32'h40,1,32'h44);
        add(0,1,0,0,            0,32'h0,0,32'hFFFFFFFC);
        add(0,1,0,0,            1,32'hFFFFFFFC,1,32'h0);
        add(0,1,0,0,            1,32'h0,1,32'h4);
        add(0,0,0,0,            1,32'h4,1,32'h8);
        // Reset beats a simultaneous redirect at count=2
        add(1,1,1,32'h40,       1,32'h4,2,32'hC);
        add(0,1,0,0,            0,32'h0,0,32'h0);
        // Back-to-back redirects: last wins
        add(0,1,1,32'h100,      1,32'h0,1,32'h4);
        add(0,1,1,32'h200,      0,32'h0,0,32'h100);
        add(0,1,0,0,            0,32'h0,0,32'h200);
        add(0,1,0,0,            1,32'h200,1,32'h204);
        add(0,1,0,0,            1,32'h204,1,32'h208);

        reset = 1'b1; inst_ready = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            chk_outputs(i, vecs[i].e_vld, vecs[i].e_pc, vecs[i].e_cnt, vecs[i].e_addr);
            reset       = vecs[i].rst;
            inst_ready  = vecs[i].rdy;
            redirect_en = vecs[i].rde;
            redirect_pc = vecs[i].rpc;
            @(posedge clock); #1;
        end

        // Sustained throughput: one new instruction every cycle with no gaps
        reset = 1'b1; inst_ready = 1'b1; redirect_en = 1'b0; redirect_pc = 32'h0;
        @(posedge clock); #1;
        reset = 1'b0;
        chk_outputs(1000, 1'b0, 32'h0, 3'd0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            @(posedge clock); #1;
            chk_outputs(1001 + i, 1'b1, 32'(4 * i), 3'd1, 32'(4 * i + 4));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
